// File: rtl/aes_addr_gen.sv
// Two-level strided address generator for the AES streamer: outer iterations x inner words.
// Optional alignment check on the job fields is enabled by defining AES_ADDR_GEN_ALIGN_CHECK_EN.
module aes_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  nb_iter_i,
    input  logic [CNT_WIDTH-1:0]  len_iter_i,
    input  logic [ADDR_WIDTH-1:0] iter_stride_i,
    input  logic [ADDR_WIDTH-1:0] word_stride_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] row_addr;
    logic [ADDR_WIDTH-1:0] iter_stride_q;
    logic [ADDR_WIDTH-1:0] word_stride_q;
    logic [CNT_WIDTH-1:0]  nb_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  outer_cnt;
    logic [CNT_WIDTH-1:0]  inner_cnt;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  align_bad;
    logic                  handshake;
    logic                  last_inner;
    logic                  last_outer;

`ifdef AES_ADDR_GEN_ALIGN_CHECK_EN
    logic err_q;

    assign align_bad = (|base_addr_i[1:0]) | (|iter_stride_i[1:0]) | (|word_stride_i[1:0]);
    assign err_o     = err_q;

    // Sticky: only clear_i or reset drop it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (clear_i) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start_i && align_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    assign align_bad = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign handshake  = valid_q && addr_ready_i;
    assign last_inner = (inner_cnt == len_q - CNT_WIDTH'(1));
    assign last_outer = (outer_cnt == nb_q - CNT_WIDTH'(1));

    assign addr_o       = addr_q;
    assign addr_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            addr_q        <= '0;
            row_addr      <= '0;
            iter_stride_q <= '0;
            word_stride_q <= '0;
            nb_q          <= '0;
            len_q         <= '0;
            outer_cnt     <= '0;
            inner_cnt     <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else if (clear_i) begin
            state         <= IDLE;
            addr_q        <= '0;
            row_addr      <= '0;
            iter_stride_q <= '0;
            word_stride_q <= '0;
            nb_q          <= '0;
            len_q         <= '0;
            outer_cnt     <= '0;
            inner_cnt     <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        addr_q        <= base_addr_i;
                        row_addr      <= base_addr_i;
                        iter_stride_q <= iter_stride_i;
                        word_stride_q <= word_stride_i;
                        nb_q          <= nb_iter_i;
                        len_q         <= len_iter_i;
                        outer_cnt     <= '0;
                        inner_cnt     <= '0;
                        busy_q        <= 1'b1;
                        // Empty or misaligned jobs skip RUN and just report completion.
                        if (align_bad || nb_iter_i == '0 || len_iter_i == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= RUN;
                            valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (last_inner && last_outer) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (last_inner) begin
                            inner_cnt <= '0;
                            outer_cnt <= outer_cnt + CNT_WIDTH'(1);
                            row_addr  <= row_addr + iter_stride_q;
                            addr_q    <= row_addr + iter_stride_q;
                        end else begin
                            inner_cnt <= inner_cnt + CNT_WIDTH'(1);
                            addr_q    <= addr_q + word_stride_q;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_addr_gen.sv
// Self-checking bench for aes_addr_gen: directed scenarios plus random jobs against a nested-loop model.
module tb_aes_addr_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] nb_iter_i;
    logic [15:0] len_iter_i;
    logic [31:0] iter_stride_i;
    logic [31:0] word_stride_i;
    logic [31:0] addr_o;
    logic        addr_valid_o;
    logic        addr_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    aes_addr_gen #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .nb_iter_i(nb_iter_i), .len_iter_i(len_iter_i),
        .iter_stride_i(iter_stride_i), .word_stride_i(word_stride_i),
        .addr_o(addr_o), .addr_valid_o(addr_valid_o), .addr_ready_i(addr_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one job and checks the address stream, handshake behaviour and completion.
    // ready_pct: chance per cycle that ready is high; stall_idx/stall_len force ready low
    // for stall_len cycles while the address with that index is offered.
    task automatic run_job(input logic [31:0] base, input int nb, input int len,
                           input logic [31:0] istr, input logic [31:0] wstr,
                           input int ready_pct, input int stall_idx, input int stall_len);
        logic [31:0] exp_q[$];
        logic [31:0] held_addr;
        logic        held;
        int          idx;
        int          cyc;
        int          stalls;
        bit          done_seen;
        int          budget;

        exp_q.delete();
        for (int o = 0; o < nb; o++)
            for (int i = 0; i < len; i++)
                exp_q.push_back(base + 32'(o) * istr + 32'(i) * wstr);

        base_addr_i   = base;
        nb_iter_i     = 16'(nb);
        len_iter_i    = 16'(len);
        iter_stride_i = istr;
        word_stride_i = wstr;
        start_i       = 1'b1;
        addr_ready_i  = 1'b0;
        step();
        start_i = 1'b0;

        idx = 0; cyc = 0; stalls = 0; held = 1'b0; held_addr = '0; done_seen = 1'b0;
        budget = 20 * (exp_q.size() + 2) + stall_len;
        while (!done_seen && cyc < budget) begin
            check("busy_in_job", busy_o, 1'b1);
            if (held) begin
                check("valid_held", addr_valid_o, 1'b1);
                check("addr_held", addr_o, held_addr);
            end
            if (addr_valid_o) begin
                if (idx < exp_q.size()) check("addr", addr_o, exp_q[idx]);
                else                    check("extra_addr", idx, exp_q.size() - 1);
            end
            if (done_o) begin
                done_seen = 1'b1;
                check("all_addrs_issued", idx, exp_q.size());
                check("valid_low_at_done", addr_valid_o, 1'b0);
                if (ready_pct == 100 && stall_len == 0)
                    check("done_latency", cyc, exp_q.size());
            end
            if (idx == stall_idx && addr_valid_o && stalls < stall_len) begin
                addr_ready_i = 1'b0;
                stalls++;
            end else begin
                addr_ready_i = ($urandom_range(99) < ready_pct);
            end
            held      = addr_valid_o && !addr_ready_i;
            held_addr = addr_o;
            if (addr_valid_o && addr_ready_i) idx++;
            step();
            cyc++;
        end
        if (!done_seen) check("done_timeout", 1'b0, 1'b1);
        check("done_one_cycle", done_o, 1'b0);
        check("busy_after_done", busy_o, 1'b0);
        check("valid_after_done", addr_valid_o, 1'b0);
        addr_ready_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; addr_ready_i = 1'b0;
        base_addr_i = '0; nb_iter_i = '0; len_iter_i = '0;
        iter_stride_i = '0; word_stride_i = '0;
        #12;
        check("rst_addr", addr_o, 32'h0);
        check("rst_valid", addr_valid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        rst_i = 1'b0;
        step();

        // Basic job, continuous ready
        run_job(32'h1000, 2, 3, 32'h100, 32'h4, 100, -1, 0);
        // Backpressure on the second address
        run_job(32'h1000, 2, 3, 32'h100, 32'h4, 100, 1, 3);
        // Zero length / zero iterations
        run_job(32'h1000, 2, 0, 32'h100, 32'h4, 100, -1, 0);
        run_job(32'h1000, 0, 3, 32'h100, 32'h4, 100, -1, 0);
        // Address wrap modulo 2^32
        run_job(32'hFFFF_FFF8, 1, 3, 32'h0, 32'h4, 100, -1, 0);

        // Clear after the second handshake, with start and ready also high
        base_addr_i = 32'h1000; nb_iter_i = 16'd2; len_iter_i = 16'd3;
        iter_stride_i = 32'h100; word_stride_i = 32'h4;
        start_i = 1'b1; step(); start_i = 1'b0;
        addr_ready_i = 1'b1;
        check("clr_addr0", addr_o, 32'h1000); step();
        check("clr_addr1", addr_o, 32'h1004); step();
        check("clr_addr2", addr_o, 32'h1008);
        clear_i = 1'b1; start_i = 1'b1;
        step();
        clear_i = 1'b0; start_i = 1'b0; addr_ready_i = 1'b0;
        check("clr_valid", addr_valid_o, 1'b0);
        check("clr_busy", busy_o, 1'b0);
        check("clr_done", done_o, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("clr_no_done", done_o, 1'b0);
            check("clr_stay_idle", busy_o, 1'b0);
        end
        run_job(32'h1000, 2, 3, 32'h100, 32'h4, 100, -1, 0);

        // Reset mid-job abandons it without done
        base_addr_i = 32'h2000; nb_iter_i = 16'd3; len_iter_i = 16'd3;
        start_i = 1'b1; step(); start_i = 1'b0;
        addr_ready_i = 1'b1; step(); step();
        rst_i = 1'b1; #1;
        check("midrst_valid", addr_valid_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_addr", addr_o, 32'h0);
        check("midrst_done", done_o, 1'b0);
        addr_ready_i = 1'b0;
        step(); rst_i = 1'b0; step();
        check("midrst_no_done", done_o, 1'b0);

`ifdef AES_ADDR_GEN_ALIGN_CHECK_EN
        base_addr_i = 32'h1002; nb_iter_i = 16'd2; len_iter_i = 16'd3;
        iter_stride_i = 32'h100; word_stride_i = 32'h4;
        start_i = 1'b1; step(); start_i = 1'b0;
        check("align_err", err_o, 1'b1);
        check("align_done", done_o, 1'b1);
        check("align_no_valid", addr_valid_o, 1'b0);
        step(); step();
        check("align_err_sticky", err_o, 1'b1);
        clear_i = 1'b1; step(); clear_i = 1'b0;
        check("align_err_cleared", err_o, 1'b0);
`endif

        // Random jobs
        for (int j = 0; j < 40; j++) begin
            logic [31:0] b, is, ws;
            b  = $urandom;
            is = $urandom_range(0, 4095);
            ws = $urandom_range(0, 64);
`ifdef AES_ADDR_GEN_ALIGN_CHECK_EN
            b[1:0] = 2'b00; is[1:0] = 2'b00; ws[1:0] = 2'b00;
`endif
            run_job(b, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), is, ws,
                    int'($urandom_range(30, 100)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 3)));
            if ($urandom_range(3) == 0) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
